// File: rtl/ddr_test_gen_if.sv
// Burst-side handshake between the DDR2 traffic generator (master) and the
// DDR2 burst controller (slave). Write and read channels share burst_finish.
interface ddr_test_gen_if;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [63:0] wr_burst_data;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [63:0] rd_burst_data;
    logic        burst_finish;

    modport master (
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data, burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output wr_burst_data_req, rd_burst_data_valid, rd_burst_data, burst_finish
    );
endinterface

// File: rtl/ddr_test_gen.sv
// DDR2 memory traffic generator and checker. Writes an address-derived
// pattern one burst at a time, reads each burst back and compares every word,
// walking ADDR_BASE..ADDR_LAST repeatedly while test_en is high.
// Optional feature: define DDR_TEST_ERR_INJECT_EN to add the err_inject input,
// which corrupts bit 0 of word 0 of a burst when sampled high on write entry.
module ddr_test_gen #(
    parameter logic [9:0]  BURST_LEN = 10'd128,
    parameter logic [23:0] ADDR_BASE = 24'h000000,
    parameter logic [23:0] ADDR_LAST = 24'h0FFF80
) (
    input  logic                  mem_clk,
    input  logic                  rst,
    input  logic                  test_en,
`ifdef DDR_TEST_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    ddr_test_gen_if.master        bus,
    output logic                  busy,
    output logic                  error,
    output logic [15:0]           err_cnt,
    output logic [15:0]           pass_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_NEXT} state_e;

    // Word k of the burst at A: w = A+k (24-bit), sent as {w, ~w} over 32-bit halves.
    function automatic logic [63:0] pattern(input logic [23:0] a, input logic [9:0] k);
        logic [31:0] w;
        w = {8'd0, a + {14'd0, k}};
        return {w, ~w};
    endfunction

    logic inject_in;
`ifdef DDR_TEST_ERR_INJECT_EN
    assign inject_in = err_inject;
`else
    assign inject_in = 1'b0;
`endif

    state_e      state_q,    state_d;
    logic        wr_req_q,   wr_req_d;
    logic        rd_req_q,   rd_req_d;
    logic [23:0] addr_q,     addr_d;
    logic [63:0] wr_data_q,  wr_data_d;
    logic [9:0]  wr_beat_q,  wr_beat_d;
    logic [9:0]  rd_beat_q,  rd_beat_d;
    logic        inject_q,   inject_d;
    logic        error_q,    error_d;
    logic [15:0] err_cnt_q,  err_cnt_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic        busy_q,     busy_d;
    logic        start_wr;
    logic [63:0] wr_word;

    // Next-state and datapath: sequences write/read pairs and checks read data.
    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch can infer a latch.
        state_d    = state_q;
        wr_req_d   = wr_req_q;
        rd_req_d   = rd_req_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        wr_beat_d  = wr_beat_q;
        rd_beat_d  = rd_beat_q;
        inject_d   = inject_q;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;
        pass_cnt_d = pass_cnt_q;
        start_wr   = 1'b0;

        wr_word = pattern(addr_q, wr_beat_q);
        if (inject_q && (wr_beat_q == 10'd0)) begin
            wr_word[0] = ~wr_word[0];
        end

        case (state_q)
            ST_IDLE: begin
                start_wr = test_en;
            end
            ST_WR: begin
                if (bus.wr_burst_data_req) begin
                    wr_data_d = wr_word;
                    // Extra requests past the burst repeat the last word.
                    if (wr_beat_q != BURST_LEN - 10'd1) begin
                        wr_beat_d = wr_beat_q + 10'd1;
                    end
                end
                // Drop req on the finish edge so the controller cannot relaunch.
                if (bus.burst_finish) begin
                    wr_req_d  = 1'b0;
                    rd_req_d  = 1'b1;
                    rd_beat_d = 10'd0;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                // A valid coinciding with burst_finish is still checked.
                if (bus.rd_burst_data_valid) begin
                    if (bus.rd_burst_data != pattern(addr_q, rd_beat_q)) begin
                        error_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                    rd_beat_d = rd_beat_q + 10'd1;
                end
                if (bus.burst_finish) begin
                    rd_req_d = 1'b0;
                    state_d  = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d     = ADDR_BASE;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end else begin
                    addr_d = addr_q + {14'd0, BURST_LEN};
                end
                state_d  = ST_IDLE;
                start_wr = test_en;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_wr) begin
            state_d   = ST_WR;
            wr_req_d  = 1'b1;
            wr_beat_d = 10'd0;
            inject_d  = inject_in;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State register with synchronous reset shared with the controller.
    always_ff @(posedge mem_clk) begin
        // NOTE: non-blocking assignments only; reset is sampled on the clock edge.
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_q     <= ADDR_BASE;
            wr_data_q  <= 64'd0;
            wr_beat_q  <= 10'd0;
            rd_beat_q  <= 10'd0;
            inject_q   <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= 16'd0;
            pass_cnt_q <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            wr_beat_q  <= wr_beat_d;
            rd_beat_q  <= rd_beat_d;
            inject_q   <= inject_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.wr_burst_req  = wr_req_q;
    assign bus.wr_burst_len  = BURST_LEN;
    assign bus.wr_burst_addr = addr_q;
    assign bus.wr_burst_data = wr_data_q;
    assign bus.rd_burst_req  = rd_req_q;
    assign bus.rd_burst_len  = BURST_LEN;
    assign bus.rd_burst_addr = addr_q;
    assign busy              = busy_q;
    assign error             = error_q;
    assign err_cnt           = err_cnt_q;
    assign pass_cnt          = pass_cnt_q;

endmodule

// File: tb/tb_ddr_test_gen.sv
// Directed testbench for ddr_test_gen: the bench plays the burst controller
// with an ideal 32-word memory, BURST_LEN=8, region 0..16 (three bursts).
module tb_ddr_test_gen;
    localparam logic [9:0]  BL   = 10'd8;
    localparam logic [23:0] BASE = 24'd0;
    localparam logic [23:0] LAST = 24'd16;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        test_en;
    logic        err_inject;
    logic        busy;
    logic        error;
    logic [15:0] err_cnt;
    logic [15:0] pass_cnt;

    int          errors  = 0;
    int          checks  = 0;
    int          exp_err = 0;
    logic [63:0] mem [0:31];

    ddr_test_gen_if bus();

    ddr_test_gen #(.BURST_LEN(BL), .ADDR_BASE(BASE), .ADDR_LAST(LAST)) dut (
        .mem_clk  (mem_clk),
        .rst      (rst),
        .test_en  (test_en),
`ifdef DDR_TEST_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .bus      (bus),
        .busy     (busy),
        .error    (error),
        .err_cnt  (err_cnt),
        .pass_cnt (pass_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    function automatic logic [63:0] pat(input logic [23:0] a, input int k);
        logic [31:0] w;
        w = {8'd0, a + 24'(k)};
        return {w, ~w};
    endfunction

    function automatic int idx(input logic [23:0] a, input int k);
        return (int'(a) + k) % 32;
    endfunction

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge mem_clk);
    endtask

    task automatic wait_wr_req();
        int n;
        n = 0;
        while (bus.wr_burst_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.wr_burst_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_req_timeout: wr_burst_req=%b after %0d cycles, want 1", bus.wr_burst_req, n);
        end
    endtask

    task automatic do_write(input logic [23:0] a, input bit gaps, input bit extra,
                            input bit inj, input bit drop_en);
        logic [63:0] exp;
        wait_wr_req();
        checks++;
        if (bus.wr_burst_addr !== a || bus.rd_burst_addr !== a || bus.wr_burst_len !== BL) begin
            errors++;
            $display("FAIL wr_addr: wr=%h rd=%h len=%0d, want addr %h len %0d",
                     bus.wr_burst_addr, bus.rd_burst_addr, bus.wr_burst_len, a, BL);
        end
        for (int k = 0; k < int'(BL); k++) begin
            bus.wr_burst_data_req = 1'b1;
            tick();
            bus.wr_burst_data_req = 1'b0;
            exp = pat(a, k);
            if (inj && k == 0) exp[0] = ~exp[0];
            checks++;
            if (bus.wr_burst_data !== exp) begin
                errors++;
                $display("FAIL wr_data A=%0d k=%0d: got %h want %h", a, k, bus.wr_burst_data, exp);
            end
            if (a == 24'd8 && k == 3) begin
                checks++;
                if (bus.wr_burst_data !== 64'h0000000BFFFFFFF4) begin
                    errors++;
                    $display("FAIL wr_data_k3: got %h want 0000000bfffffff4", bus.wr_burst_data);
                end
            end
            mem[idx(a, k)] = bus.wr_burst_data;
            if (drop_en && k == 2) test_en = 1'b0;
            if (gaps && (k % 2 == 1)) begin
                tick();
                checks++;
                if (bus.wr_burst_data !== exp) begin
                    errors++;
                    $display("FAIL wr_data_hold k=%0d: got %h want %h", k, bus.wr_burst_data, exp);
                end
            end
        end
        if (extra) begin
            bus.wr_burst_data_req = 1'b1;
            tick();
            bus.wr_burst_data_req = 1'b0;
            checks++;
            if (bus.wr_burst_data !== pat(a, int'(BL) - 1)) begin
                errors++;
                $display("FAIL wr_data_sat: got %h want %h", bus.wr_burst_data, pat(a, int'(BL) - 1));
            end
        end
        bus.burst_finish = 1'b1;
        tick();
        bus.burst_finish = 1'b0;
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_to_rd: wr_req=%b rd_req=%b, want 0 1", bus.wr_burst_req, bus.rd_burst_req);
        end
    endtask

    task automatic do_read(input logic [23:0] a, input int bad_k, input int n_beats, input bit inj);
        for (int k = 0; k < n_beats; k++) begin
            bus.rd_burst_data_valid = 1'b1;
            bus.rd_burst_data       = mem[idx(a, k)];
            if (k == bad_k) bus.rd_burst_data[40] = ~bus.rd_burst_data[40];
            bus.burst_finish = (k == int'(BL) - 1);
            tick();
            bus.rd_burst_data_valid = 1'b0;
            bus.burst_finish        = 1'b0;
            if (k == bad_k || (inj && k == 0)) begin
                exp_err++;
                checks++;
                if (error !== 1'b1 || err_cnt !== 16'(exp_err)) begin
                    errors++;
                    $display("FAIL rd_mismatch A=%0d k=%0d: error=%b err_cnt=%0d, want 1 %0d",
                             a, k, error, err_cnt, exp_err);
                end
            end
        end
        if (n_beats == int'(BL)) begin
            checks++;
            if (bus.rd_burst_req !== 1'b0 || busy !== 1'b1 || err_cnt !== 16'(exp_err)
                || error !== (exp_err != 0)) begin
                errors++;
                $display("FAIL rd_done A=%0d: rd_req=%b busy=%b err_cnt=%0d error=%b, want 0 1 %0d %b",
                         a, bus.rd_burst_req, busy, err_cnt, error, exp_err, exp_err != 0);
            end
        end
    endtask

    task automatic run_pair(input logic [23:0] a, input bit gaps, input bit extra,
                            input bit inj, input bit drop_en, input int bad_k);
        do_write(a, gaps, extra, inj, drop_en);
        do_read(a, bad_k, int'(BL), inj);
    endtask

    task automatic check_wrap(input int exp_pass);
        tick();
        checks++;
        if (pass_cnt !== 16'(exp_pass) || bus.wr_burst_addr !== BASE || bus.wr_burst_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pass_cnt=%0d addr=%h wr_req=%b, want %0d %h 1",
                     pass_cnt, bus.wr_burst_addr, bus.wr_burst_req, exp_pass, BASE);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0 || busy !== 1'b0
            || bus.wr_burst_addr !== BASE || bus.wr_burst_data !== 64'd0 || error !== 1'b0
            || err_cnt !== 16'd0 || pass_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s: wr_req=%b rd_req=%b busy=%b addr=%h data=%h error=%b err_cnt=%0d pass_cnt=%0d, want all zero",
                     tag, bus.wr_burst_req, bus.rd_burst_req, busy, bus.wr_burst_addr,
                     bus.wr_burst_data, error, err_cnt, pass_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        test_en = 1'b0;
        tick();
        tick();
        exp_err = 0;
        check_reset_state("reset");
        rst = 1'b0;
        tick();
        check_reset_state("idle_disabled");
    endtask

    task automatic test_clean_pass();
        test_en = 1'b1;
        run_pair(24'd0,  1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd8,  1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_pair(24'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_wrap(1);
    endtask

    task automatic test_corruption();
        run_pair(24'd0,  1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd8,  1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_pair(24'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_wrap(2);
        run_pair(24'd0,  1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd8,  1'b0, 1'b0, 1'b0, 1'b0, 5);
        run_pair(24'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_wrap(3);
    endtask

    task automatic test_enable_drop();
        run_pair(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        tick();
        checks++;
        if (busy !== 1'b0 || bus.wr_burst_req !== 1'b0 || bus.wr_burst_addr !== 24'd16) begin
            errors++;
            $display("FAIL en_drop_idle: busy=%b wr_req=%b addr=%h, want 0 0 000010",
                     busy, bus.wr_burst_req, bus.wr_burst_addr);
        end
        // Stray controller activity while idle must be ignored.
        bus.burst_finish        = 1'b1;
        bus.rd_burst_data_valid = 1'b1;
        bus.rd_burst_data       = 64'hDEAD_BEEF_0000_0001;
        tick();
        bus.burst_finish        = 1'b0;
        bus.rd_burst_data_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.rd_burst_req !== 1'b0 || err_cnt !== 16'(exp_err)
            || bus.wr_burst_addr !== 24'd16) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b rd_req=%b err_cnt=%0d addr=%h, want 0 0 %0d 000010",
                     busy, bus.rd_burst_req, err_cnt, exp_err, bus.wr_burst_addr);
        end
        test_en = 1'b1;
        run_pair(24'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_wrap(4);
    endtask

    task automatic test_reset_mid_rd();
        do_write(24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_read(24'd0, -1, 3, 1'b0);
        rst = 1'b1;
        tick();
        exp_err = 0;
        check_reset_state("reset_mid_rd");
        rst = 1'b0;
        run_pair(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    endtask

`ifdef DDR_TEST_ERR_INJECT_EN
    task automatic test_err_inject();
        rst = 1'b1;
        err_inject = 1'b1;
        tick();
        exp_err = 0;
        rst = 1'b0;
        tick();
        err_inject = 1'b0;
        run_pair(24'd0,  1'b0, 1'b0, 1'b1, 1'b0, -1);
        run_pair(24'd8,  1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_pair(24'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_wrap(1);
        checks++;
        if (err_cnt !== 16'd1 || error !== 1'b1) begin
            errors++;
            $display("FAIL inject_total: err_cnt=%0d error=%b, want 1 1", err_cnt, error);
        end
    endtask
`endif

    initial begin
        rst                     = 1'b1;
        test_en                 = 1'b0;
        err_inject              = 1'b0;
        bus.wr_burst_data_req   = 1'b0;
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_data       = 64'd0;
        bus.burst_finish        = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 64'd0;

        test_reset();
        test_clean_pass();
        test_corruption();
        test_enable_drop();
        test_reset_mid_rd();
`ifdef DDR_TEST_ERR_INJECT_EN
        test_err_inject();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_test_gen.md
Name: ddr_test_gen

Overview:
- Traffic generator and checker that drives the burst-side interface of the DDR2 burst controller (rd/wr_burst_* handshake) from upstream.
- Writes a deterministic address-derived pattern in fixed-length bursts, reads each burst back, and compares every returned word.
- Walks the whole test region, wraps, and repeats while enabled.
- Reports a sticky error, an error count and a pass count for board-level memory bring-up.

Parameters:
BURST_LEN, 10'd128, words per burst (64-bit word units); even, 2..1022
ADDR_BASE, 24'h000000, first word address of test region
ADDR_LAST, 24'h0FFF80, start address of final burst in region; (ADDR_LAST-ADDR_BASE) multiple of BURST_LEN

Ports:
mem_clk  in  1  controller clock; all logic on rising edge
rst  in  1  synchronous active-high reset
test_en  in  1  run enable; level
wr_burst_req  out  1  write burst request to controller
wr_burst_len  out  10  always BURST_LEN
wr_burst_addr  out  24  current burst start address
wr_burst_data_req  in  1  controller requests next write word
wr_burst_data  out  64  write data word
rd_burst_req  out  1  read burst request to controller
rd_burst_len  out  10  always BURST_LEN
rd_burst_addr  out  24  current burst start address (same as wr_burst_addr)
rd_burst_data_valid  in  1  read word valid
rd_burst_data  in  64  read data word
burst_finish  in  1  one-cycle pulse, current burst complete
busy  out  1  high whenever state != IDLE
error  out  1  sticky mismatch flag
err_cnt  out  16  mismatching words, saturates at 16'hFFFF
pass_cnt  out  16  completed full-region passes, wraps

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, both reqs 0, burst addr=ADDR_BASE, wr_burst_data=0, beat counters 0, error=0, err_cnt=0, pass_cnt=0, busy=0. Reset mid-burst abandons the burst immediately; controller shares this reset.
- Pattern for word k of burst at address A: w=A+k (24-bit, zero-extended to 32); word={w[31:0], ~w[31:0]}.
- States: IDLE, WR, RD, NEXT.
- IDLE: if test_en, next state WR, wr_burst_req<=1.
- WR: wr_burst_req held high until the edge sampling burst_finish=1. At that edge: wr_burst_req<=0, rd_burst_req<=1, go RD. Req must be low the cycle after burst_finish so the controller does not relaunch.
- Write data: wr_beat counter reset to 0 on WR entry. On each cycle with wr_burst_data_req=1, register wr_burst_data<=pattern(A, wr_beat) and increment wr_beat. Data for request n is therefore valid the cycle after request n.
- wr_beat saturates at BURST_LEN-1; extra requests repeat the last word.
- RD: rd_burst_req held until burst_finish, then dropped; go NEXT.
- Read check: rd_beat reset on RD entry. Each rd_burst_data_valid compares rd_burst_data against pattern(A, rd_beat), then increments rd_beat.
- On mismatch: error<=1 and err_cnt+1, saturating.
- burst_finish may coincide with the last valid; that word is still checked.
- NEXT (1 cycle):
  - If A==ADDR_LAST: A<=ADDR_BASE and pass_cnt+1.
  - Else A<=A+BURST_LEN.
  - Then if test_en, go WR with wr_burst_req<=1; else go IDLE.
- test_en deassert mid-burst: current write+read pair completes, then IDLE. Address and counters are retained, so re-enable resumes at the next burst.
- burst_finish in IDLE or NEXT is ignored. rd_burst_data_valid outside RD is ignored (not counted, not checked).
- error and err_cnt clear only on rst.

Optional Feature:
- Macro DDR_TEST_ERR_INJECT_EN.
- Defined: adds input err_inject (1 bit). err_inject sampled on WR entry; if high, word 0 of that burst is written with bit 0 inverted. The read-back then yields exactly one mismatch per injected burst.
- Undefined: port absent; pattern always clean.

Test Plan:
- Clean pass, BURST_LEN=8, ADDR_LAST=ADDR_BASE+16, ideal memory model -> 3 write/read pairs at addresses 0,8,16; pass_cnt=1 after third NEXT; error=0, err_cnt=0.
- Write data timing: wr_burst_data_req pulsed at k=0..7 with gaps -> word k appears the cycle after its req with value {A+k, ~(A+k)}, e.g. k=3, A=8 -> 64'h0000000BFFFFFFF4.
- Corruption: memory model flips bit 40 of read word 5 of burst at A=8 -> error=1 after that valid, err_cnt=1, pass continues; a second corrupted pass -> err_cnt=2.
- test_en dropped during WR of burst A=8 -> read of A=8 completes, busy falls after NEXT, wr_burst_addr holds 16; re-enable -> next write at 16.
- Sync reset asserted mid-RD -> next edge: reqs 0, busy 0, addr ADDR_BASE, error/err_cnt/pass_cnt 0; with test_en high, restart at ADDR_BASE.
- With DDR_TEST_ERR_INJECT_EN, err_inject=1 at WR entry for A=0 -> err_cnt=1 exactly, error=1; err_inject=0 on following bursts -> no further increments.
